// File: rtl/regfile_wr_arbiter_if.sv
// Write-port arbiter bus: writeback stage, long-unit handshake, register-file write and status.
interface regfile_wr_arbiter_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4
);
    logic                             pipe_en;
    logic        [REG_ADDR_WIDTH-1:0] pipe_addr;
    logic signed [DATA_WIDTH-1:0]     pipe_data;
    logic                             lu_valid;
    logic                             lu_ready;
    logic        [REG_ADDR_WIDTH-1:0] lu_addr;
    logic signed [DATA_WIDTH-1:0]     lu_data;
    logic                             rf_we;
    logic        [REG_ADDR_WIDTH-1:0] rf_addr;
    logic signed [DATA_WIDTH-1:0]     rf_data;
    logic                             stall_out;
    logic                             pending;

    modport master (
        output pipe_en, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
        input  lu_ready, rf_we, rf_addr, rf_data, stall_out, pending
    );

    modport slave (
        input  pipe_en, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
        output lu_ready, rf_we, rf_addr, rf_data, stall_out, pending
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between writeback and a buffered long-latency unit (WB_WAW_SQUASH_EN squashes stale results).
// Latency: pipe path 1 cycle; long-unit path 2 cycles minimum (accept, then pop into an idle slot).
// Backpressure: lu_ready drops while the FIFO is full; a head blocked STARVE_LIMIT cycles raises stall_out.
module regfile_wr_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH     = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                 clk_in,
    input  logic                 RST,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic        [PW:0]               wr_ptr, rd_ptr;
    logic        [PW-1:0]             wr_idx, rd_idx;
    logic        [REG_ADDR_WIDTH-1:0] q_addr [FIFO_DEPTH];
    logic signed [DATA_WIDTH-1:0]     q_data [FIFO_DEPTH];
    logic        [FIFO_DEPTH-1:0]     q_live, live_nxt;
    logic        [CW-1:0]             starve_cnt;
    logic                             stall_q;
    logic                             rf_we_q;
    logic        [REG_ADDR_WIDTH-1:0] rf_addr_q;
    logic signed [DATA_WIDTH-1:0]     rf_data_q;

    logic empty, full, head_live, head_squash;
    logic push, live_pop, dead_pop, pop, blocked;

    assign wr_idx = wr_ptr[PW-1:0];
    assign rd_idx = rd_ptr[PW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);

    assign head_live = !empty && q_live[rd_idx];
    assign push      = bus.lu_valid && bus.lu_ready;
    assign live_pop  = head_live && !bus.pipe_en;
    assign dead_pop  = !empty && !q_live[rd_idx];
    assign pop       = live_pop || dead_pop;

`ifdef WB_WAW_SQUASH_EN
    // A head squashed this edge is about to become dead, so it is not starving.
    assign head_squash = bus.pipe_en && head_live && (q_addr[rd_idx] == bus.pipe_addr);
`else
    assign head_squash = 1'b0;
`endif
    assign blocked = head_live && bus.pipe_en && !head_squash;

    always_comb begin
        live_nxt = q_live;
`ifdef WB_WAW_SQUASH_EN
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (bus.pipe_en && (q_addr[i] == bus.pipe_addr)) begin
                live_nxt[i] = 1'b0;
            end
        end
`endif
        if (pop) begin
            live_nxt[rd_idx] = 1'b0;
        end
        // The freshly accepted entry is younger than the pipe write and stays live.
        if (push) begin
            live_nxt[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_live     <= '0;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
            q_live <= live_nxt;

            if (bus.pipe_en) begin
                rf_we_q   <= 1'b1;
                rf_addr_q <= bus.pipe_addr;
                rf_data_q <= bus.pipe_data;
            end else if (live_pop) begin
                rf_we_q   <= 1'b1;
                rf_addr_q <= q_addr[rd_idx];
                rf_data_q <= q_data[rd_idx];
            end else begin
                rf_we_q   <= 1'b0;
            end

            if (pop || empty) begin
                starve_cnt <= '0;
            end else if (blocked && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + CW'(1);
            end

            if (live_pop) begin
                stall_q <= 1'b0;
            end else if (blocked && (starve_cnt >= LIMIT - CW'(1))) begin
                stall_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            q_addr[wr_idx] <= bus.lu_addr;
            q_data[wr_idx] <= bus.lu_data;
        end
    end

    assign bus.lu_ready  = RST && !full;
    assign bus.pending   = !empty;
    assign bus.stall_out = stall_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_addr   = rf_addr_q;
    assign bus.rf_data   = rf_data_q;
endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the single register-file write port between the in-order writeback stage and one long-latency unit, such as a multi-cycle divider or memory. The long-latency unit hands its results over with a valid/ready handshake. The block buffers them in a small FIFO and drains them into idle writeback slots. If the FIFO is blocked too long, it asks the front of the pipeline for a bubble. The block sits between writeback and the register file, and all of its outputs are registered.

## Interface
- DATA_WIDTH, 16, register data width (signed)
- REG_ADDR_WIDTH, 4, register address width
- FIFO_DEPTH, 2, long-unit result buffer entries; power of two, ≥2
- STARVE_LIMIT, 4, consecutive blocked cycles before stall request; ≥1
- clk_in  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-low
- pipe_en  in  1  writeback stage write enable (highest priority, never back-pressured)
- pipe_addr  in  REG_ADDR_WIDTH  writeback destination register
- pipe_data  in  DATA_WIDTH  writeback data
- lu_valid  in  1  long-unit result valid
- lu_ready  out  1  arbiter can accept a long-unit result
- lu_addr  in  REG_ADDR_WIDTH  long-unit destination register
- lu_data  in  DATA_WIDTH  long-unit result
- rf_we  out  1  register-file write enable
- rf_addr  out  REG_ADDR_WIDTH  register-file write address
- rf_data  out  DATA_WIDTH  register-file write data
- stall_out  out  1  bubble request to the upstream pipeline
- pending  out  1  FIFO non-empty (includes squashed entries)

## Operation
- **Reset.** While RST=0 at an edge, the block sets:
  - rf_we=0, rf_addr=0, rf_data=0
  - stall_out=0
  - FIFO empty, with all entry live bits cleared
  - starve counter=0
- **lu_ready.** lu_ready = RST & !full. It depends only on registered state.
- **Accept.** A result is accepted when lu_valid & lu_ready. It is pushed at the tail as a live entry with {lu_addr, lu_data}.
- **Full FIFO.** There is no push-through when full: a pop in the same cycle does not raise lu_ready.
- **Port priority, each cycle:**
  1. If pipe_en=1, register {1, pipe_addr, pipe_data} onto rf_*.
  2. Otherwise, if the FIFO is non-empty and its head is live, pop the head and register {1, head.addr, head.data}.
  3. Otherwise, register rf_we=0, with rf_addr and rf_data holding their previous values.
- **Dead-head pop.** A head whose live bit is cleared is popped in any cycle, whether pipe_en is 0 or 1. No write is issued for it; rf_we comes from the pipe rule.
- **Starvation counter:**
  - Increments on each cycle where the FIFO is non-empty, the head is live, and pipe_en=1.
  - Saturates at STARVE_LIMIT.
  - Clears to 0 on any pop or when the FIFO is empty.
- **stall_out:**
  - Set at the edge where the counter reaches STARVE_LIMIT.
  - Cleared at the edge of the next live pop.
- **Upstream contract.** While stall_out=1, upstream forces pipe_en=0 from the following cycle onward.
- **Simultaneous push and pop.** Both are allowed; the FIFO count is unchanged.
- **Pointers.** Both pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.

## Timing
- **Pipe path latency.** 1 cycle: pipe_* sampled at edge E appears on rf_* after E.
- **Long-unit path latency.** The minimum is 2 cycles: an accept at edge E makes the entry visible in the FIFO after E, and the earliest pop is at E+1.
- **stall_out timing.** The earliest assertion is STARVE_LIMIT edges after the first blocked cycle. stall_out deasserts on the same edge that registers the drained write.
- **Reset mid-operation.** Buffered results are discarded, not written. Upstream reissues them.

## Configuration
- **Macro:** WB_WAW_SQUASH_EN.
- **Defined:**
  - When pipe_en=1, every live FIFO entry with addr==pipe_addr has its live bit cleared at that edge. This prevents an older long-unit result from overwriting a younger pipeline write.
  - An entry accepted in the same cycle is not squashed.
  - Squashed entries do not count toward starvation.
- **Undefined:**
  - Live bits never clear, and entries drain in FIFO order regardless of address.
  - rf_we on a popped head is always 1.

## Test plan
- **Reset:** hold RST=0 for 3 cycles with lu_valid=1 and pipe_en=1 → rf_we=0, stall_out=0, pending=0 and lu_ready=0 throughout; lu_ready=1 in the first cycle after release.
- **Idle drain:** pipe_en=0, accept {addr 5, data -3} in cycle 0 → rf_we=1, rf_addr=5, rf_data=-3 registered at edge 1 and visible in cycle 2; pending=0 afterwards.
- **Back-pressure:** pipe_en=1 continuously, 3 offered results → 2 are accepted and lu_ready=0 after that. stall_out rises once the counter reaches 4. After pipe_en drops, entries drain in order, with the third accepted only once the FIFO is no longer full.
- **Priority:** pipe_en=1 (addr 2, 7) in the same cycle a live head {addr 3, 9} is present → rf writes 2/7, then 3/9 on the next idle cycle.
- **Squash (WB_WAW_SQUASH_EN):** FIFO holds {addr 4, 11}, then pipe_en=1 writes addr 4 with 20 → rf writes 4/20. The entry pops with rf_we=0 and the register keeps 20. Without the macro, a later 4/11 write follows.
- **Wrap-around:** 10 back-to-back accepts with pipe_en=0 → all 10 written in order, with no loss or duplication across pointer wrap.
